// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART report scheduler.
// Frame layout: SYNC, HDR={tag,seq}, PAYLOAD, CSUM.
package uart_sched_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [3:0] TAG_HEARTBEAT = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    HDR,
    PAY,
    CSUM
  } sched_state_e;

  function automatic logic [7:0] csum8(
    input logic [7:0] hdr,
    input logic [7:0] pay
  );
    return SYNC_BYTE ^ hdr ^ pay;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past
// the last grant and wraps, giving one-hot grant plus its index.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int            j;
  logic [IW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(last_i) + 1 + i;
      if (j >= N) j = j - N;
      k = IW'(j);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/uart_report_sched.sv
// Arbitrates report sources onto one uart_tx byte channel,
// framing each payload and emitting heartbeats on idle links.
module uart_report_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int HB_CYCLES = 22_500_000
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (HB_CYCLES > 0) ? $clog2(HB_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HB_MAX =
    (HB_CYCLES > 0) ? HW'(HB_CYCLES - 1) : '0;

  sched_state_e  state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    tag_q, tag_d;
  logic [7:0]    pay_q, pay_d;
  logic [3:0]    seq_q, seq_d;
  logic [HW-1:0] hb_q, hb_d;
  logic [IW-1:0] last_q, last_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [7:0]         gnt_pay;
  logic               hs;
  logic               hb_fire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  always_comb begin
    gnt_pay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_pay = req_data_i[8*i +: 8];
    end
  end

  assign valid_o = (state_q != IDLE);
  assign busy_o  = (state_q != IDLE);
  assign data_o  = data_q;
  assign hs      = valid_o & ready_i;
  assign hb_fire = (HB_CYCLES != 0) && (hb_q == HB_MAX);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tag_d       = tag_q;
    pay_d       = pay_q;
    seq_d       = seq_q;
    last_d      = last_q;
    hb_d        = (hb_q == HB_MAX) ? hb_q : hb_q + 1'b1;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = gnt;
        // A waiting requester always pre-empts the heartbeat.
        if (gnt_any) begin
          tag_d   = 4'(gnt_idx);
          pay_d   = gnt_pay;
          last_d  = gnt_idx;
          data_d  = SYNC_BYTE;
          hb_d    = '0;
          state_d = SYNC;
        end else if (hb_fire) begin
          tag_d   = TAG_HEARTBEAT;
          pay_d   = 8'h00;
          data_d  = SYNC_BYTE;
          hb_d    = '0;
          state_d = SYNC;
        end
      end
      SYNC: if (hs) begin
        data_d  = {tag_q, seq_q};
        state_d = HDR;
      end
      HDR: if (hs) begin
        data_d  = pay_q;
        state_d = PAY;
      end
      PAY: if (hs) begin
        data_d  = csum8({tag_q, seq_q}, pay_q);
        state_d = CSUM;
      end
      CSUM: if (hs) begin
        data_d  = 8'h00;
        seq_d   = seq_q + 4'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      tag_q   <= 4'h0;
      pay_q   <= 8'h00;
      seq_q   <= 4'h0;
      hb_q    <= '0;
      last_q  <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      pay_q   <= pay_d;
      seq_q   <= seq_d;
      hb_q    <= hb_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_report_sched.sv
// Scoreboard bench for uart_report_sched: expected frame bytes
// are queued at stimulus time and popped on each handshake.
module tb_uart_report_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        busy;

  uart_report_sched #(.NUM_REQ(3), .HB_CYCLES(16)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel   = 0;
  int acc_n = 0;
  int hs_n  = 0;

  logic [7:0] exp_q[$];
  int         hs_cyc[$];
  int         acc_cyc[$];
  int         gnt_q[$];

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_cs(input logic [7:0] h,
                                        input logic [7:0] p);
    return 8'hA5 ^ h ^ p;
  endfunction

  task automatic push_frame(input logic [3:0] tag,
                            input logic [3:0] seq,
                            input logic [7:0] pay);
    exp_q.push_back(8'hA5);
    exp_q.push_back({tag, seq});
    exp_q.push_back(pay);
    exp_q.push_back(exp_cs({tag, seq}, pay));
  endtask

  // Monitor: pops the scoreboard on handshakes, records accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr) begin
        total++;
        if (valid !== 1'b1 || data !== pd) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%h want valid=1 data=%h",
                   valid, data, pd);
        end
      end
      if (busy) begin
        total++;
        if (req_ready !== 3'b000) begin
          bad++;
          $display("FAIL ready_busy: req_ready=%b want 000", req_ready);
        end
      end
      if (valid && ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: byte=%h want none", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            bad++;
            $display("FAIL sb_byte: got=%h want=%h", data, e);
          end
        end
        hs_cyc.push_back(cyc);
        hs_n++;
      end
      if (|(req_valid & req_ready)) begin
        total++;
        if (!$onehot(req_ready)) begin
          bad++;
          $display("FAIL onehot: req_ready=%b want one-hot", req_ready);
        end
        for (int i = 0; i < 3; i++)
          if (req_ready[i]) gnt_q.push_back(i);
        acc_cyc.push_back(cyc);
        acc_n++;
      end
    end
    pv = valid && rst_n;
    pr = ready;
    pd = data;
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    ready     = 1'b0;
    req_valid = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    hs_cyc.delete();
    acc_cyc.delete();
    gnt_q.delete();
    rel = cyc;
  endtask

  task automatic wait_acc(input int n, input string nm);
    int k = 0;
    while (acc_n < n && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (acc_n < n) begin
      bad++;
      $display("FAIL %s accept_timeout: got=%0d want=%0d", nm, acc_n, n);
    end
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 400) begin
      @(posedge clk);
      #2;
      k++;
    end
    total++;
    if (exp_q.size() != 0 || busy) begin
      bad++;
      $display("FAIL %s drain: left=%0d busy=%b want 0 0",
               nm, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ready     = 1'b0;
    req_valid = 3'b000;
    req_data  = 24'h0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (valid !== 1'b0 || data !== 8'h00 || busy !== 1'b0 ||
        req_ready !== 3'b000) begin
      bad++;
      $display("FAIL reset: v=%b d=%h b=%b r=%b want 0 00 0 000",
               valid, data, busy, req_ready);
    end
  endtask

  task automatic test_single();
    int a0;
    int base;
    do_reset();
    base      = acc_n;
    req_data  = 24'h00002C;
    req_valid = 3'b001;
    ready     = 1'b1;
    push_frame(4'h0, 4'h0, 8'h2C);
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL first_grant: req_ready=%b want 001", req_ready);
    end
    wait_acc(base + 1, "single");
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    wait_drain("single");
    a0 = (acc_cyc.size() > 0) ? acc_cyc[0] : -100;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (hs_cyc.size() <= i || hs_cyc[i] != a0 + 1 + i) begin
        bad++;
        $display("FAIL latency[%0d]: cyc=%0d want=%0d", i,
                 (hs_cyc.size() > i) ? hs_cyc[i] : -1, a0 + 1 + i);
      end
    end
    // The second frame carries seq=1.
    req_valid = 3'b001;
    push_frame(4'h0, 4'h1, 8'h2C);
    wait_acc(base + 2, "single2");
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    wait_drain("single2");
  endtask

  task automatic test_round_robin();
    int base;
    int exp_g[4] = '{0, 1, 2, 0};
    logic [7:0] pays[3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    base      = acc_n;
    req_data  = {8'h33, 8'h22, 8'h11};
    req_valid = 3'b111;
    ready     = 1'b1;
    for (int i = 0; i < 4; i++)
      push_frame(4'(exp_g[i]), 4'(i), pays[exp_g[i]]);
    wait_acc(base + 4, "rr");
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    wait_drain("rr");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gnt_q.size() <= i || gnt_q[i] != exp_g[i]) begin
        bad++;
        $display("FAIL rr_order[%0d]: got=%0d want=%0d", i,
                 (gnt_q.size() > i) ? gnt_q[i] : -1, exp_g[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (acc_cyc.size() < 4 || acc_cyc[i+1] - acc_cyc[i] != 5) begin
        bad++;
        $display("FAIL rr_period[%0d]: got=%0d want=5", i,
                 (acc_cyc.size() >= 4) ? acc_cyc[i+1] - acc_cyc[i] : -1);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int h0;
    do_reset();
    base      = acc_n;
    req_data  = 24'h5A0000;
    req_valid = 3'b100;
    ready     = 1'b1;
    push_frame(4'h2, 4'h0, 8'h5A);
    wait_acc(base + 1, "bp");
    h0 = hs_n;
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    ready = 1'b0;
    @(posedge clk);
    #1;
    ready = 1'b0;
    @(posedge clk);
    #1;
    ready = 1'b1;
    wait_drain("bp");
    total++;
    if (hs_n - h0 != 4) begin
      bad++;
      $display("FAIL bp_count: got=%0d want=4", hs_n - h0);
    end
  endtask

  task automatic test_heartbeat();
    do_reset();
    ready = 1'b1;
    push_frame(4'hF, 4'h0, 8'h00);
    wait_drain("hb");
    total++;
    if (hs_cyc.size() == 0 || hs_cyc[0] != rel + 16) begin
      bad++;
      $display("FAIL hb_time: cyc=%0d want=%0d",
               (hs_cyc.size() > 0) ? hs_cyc[0] - rel : -1, 16);
    end
    // Request arriving on the heartbeat decision cycle wins.
    do_reset();
    ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    req_data  = 24'h006B00;
    req_valid = 3'b010;
    push_frame(4'h1, 4'h0, 8'h6B);
    wait_acc(acc_n + 1, "hb_race");
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    wait_drain("hb_race");
    total++;
    if (gnt_q.size() == 0 || gnt_q[0] != 1 ||
        acc_cyc[0] != rel + 15) begin
      bad++;
      $display("FAIL hb_race: gnt=%0d cyc=%0d want gnt=1 cyc=15",
               (gnt_q.size() > 0) ? gnt_q[0] : -1,
               (acc_cyc.size() > 0) ? acc_cyc[0] - rel : -1);
    end
  endtask

  task automatic test_seq_wrap();
    int base;
    int h0;
    do_reset();
    base      = acc_n;
    h0        = hs_n;
    req_data  = 24'h007700;
    req_valid = 3'b010;
    ready     = 1'b1;
    for (int i = 0; i < 17; i++)
      push_frame(4'h1, 4'(i), 8'h77);
    wait_acc(base + 17, "wrap");
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    wait_drain("wrap");
    total++;
    if (hs_n - h0 != 68) begin
      bad++;
      $display("FAIL wrap_count: got=%0d want=68", hs_n - h0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data  = 24'h000042;
    req_valid = 3'b001;
    ready     = 1'b1;
    exp_q.push_back(8'hA5);
    wait_acc(acc_n + 1, "mid");
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || data !== 8'h00 ||
        exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset: v=%b b=%b d=%h left=%0d want 0 0 00 0",
               valid, busy, data, exp_q.size());
    end
    rst_n     = 1'b1;
    ready     = 1'b1;
    req_valid = 3'b001;
    push_frame(4'h0, 4'h0, 8'h42);
    wait_acc(acc_n + 1, "mid2");
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    wait_drain("mid2");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: time=%0t want finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_heartbeat();
    test_seq_wrap();
    test_reset_mid();
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
